// File: rtl/dm_unit_pkg.sv
// Shared definitions for the data-memory stage: access-type codes,
// memory geometry, and the store commit record.
package dm_unit_pkg;

   typedef enum logic [2:0] {
      DM_W  = 3'd0,
      DM_H  = 3'd1,
      DM_HU = 3'd2,
      DM_B  = 3'd3,
      DM_BU = 3'd4
   } dm_op_e;

   localparam int unsigned DM_DEPTH      = 3072;
   localparam int unsigned DM_AW         = 12;
   localparam int unsigned DM_SIZE_BYTES = DM_DEPTH * 4;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] addr;
      logic [31:0] data;
   } dm_commit_t;

endpackage

// File: rtl/dm_ext.sv
// Load lane select and sign/zero extension for the data-memory read path.
module dm_ext
   import dm_unit_pkg::*;
(
   input  logic [31:0] word,
   input  logic [2:0]  op,
   input  logic [1:0]  lane,
   output logic [31:0] data_c
);

   logic [15:0] lane_half;
   logic [31:0] shifted;
   logic [7:0]  lane_byte;

   always_comb begin
      lane_half = lane[1] ? word[31:16] : word[15:0];
      shifted   = word >> {lane, 3'b000};
      lane_byte = shifted[7:0];
      data_c    = word;
      case (op)
         DM_H:    data_c = {{16{lane_half[15]}}, lane_half};
         DM_HU:   data_c = {16'h0000, lane_half};
         DM_B:    data_c = {{24{lane_byte[7]}}, lane_byte};
         DM_BU:   data_c = {24'h000000, lane_byte};
         default: data_c = word;
      endcase
   end

endmodule

// File: rtl/dm_unit.sv
// Data-memory stage: combinational loads, edge-committed word/half/byte stores
// on a little-endian word array, plus a registered store commit record.
module dm_unit
   import dm_unit_pkg::*;
#(
   parameter int unsigned DEPTH = DM_DEPTH,
   parameter int unsigned AW    = DM_AW
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [2:0]  DMOp,
   input  logic [31:0] Addr,
   input  logic [31:0] WD,
   input  logic [31:0] PC,
   output logic [31:0] RD,
   output logic        addr_exc,
   output logic        wb_valid,
   output logic [31:0] wb_pc,
   output logic [31:0] wb_addr,
   output logic [31:0] wb_data
);

   localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] idx;
   logic [31:0]   cur_word;
   logic [31:0]   ext_data;
   logic [31:0]   merged;
   logic          commit;
   dm_commit_t    rec;

   assign idx      = Addr[AW+1:2];
   assign cur_word = mem[idx];

   // Range check is a full 32-bit compare so high address bits never alias.
   always_comb begin
      addr_exc = 1'b0;
      if (Addr >= LIMIT) addr_exc = 1'b1;
      case (DMOp)
         DM_W:        if (Addr[1:0] != 2'b00) addr_exc = 1'b1;
         DM_H, DM_HU: if (Addr[0]) addr_exc = 1'b1;
         DM_B, DM_BU: ;
         default:     addr_exc = 1'b1;
      endcase
   end

   dm_ext u_ext (
      .word   (cur_word),
      .op     (DMOp),
      .lane   (Addr[1:0]),
      .data_c (ext_data)
   );

   assign RD = addr_exc ? 32'h0 : ext_data;

   // Store lane merge: selected lane replaced, the rest of the word preserved.
   always_comb begin
      merged = cur_word;
      case (DMOp)
         DM_W: merged = WD;
         DM_H, DM_HU: begin
            if (Addr[1]) merged[31:16] = WD[15:0];
            else         merged[15:0]  = WD[15:0];
         end
         DM_B, DM_BU: begin
            case (Addr[1:0])
               2'd0:    merged[7:0]   = WD[7:0];
               2'd1:    merged[15:8]  = WD[7:0];
               2'd2:    merged[23:16] = WD[7:0];
               default: merged[31:24] = WD[7:0];
            endcase
         end
         default: merged = cur_word;
      endcase
   end

   assign commit = MemWrite && !addr_exc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (commit) begin
         mem[idx] <= merged;
      end
   end

   // Commit record: payload fields hold across edges with no store.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rec <= '0;
      end else if (commit) begin
         rec.valid <= 1'b1;
         rec.pc    <= PC;
         rec.addr  <= {Addr[31:2], 2'b00};
         rec.data  <= merged;
      end else begin
         rec.valid <= 1'b0;
      end
   end

   assign wb_valid = rec.valid;
   assign wb_pc    = rec.pc;
   assign wb_addr  = rec.addr;
   assign wb_data  = rec.data;

endmodule

// File: tb/tb_dm_unit.sv
// Self-checking bench for dm_unit: behavioural byte-lane model, per-cycle
// compare on the falling edge, directed literal checks and random traffic.
module tb_dm_unit;

   localparam int unsigned NW = 3072;

   logic        clk;
   logic        rst;
   logic        we;
   logic [2:0]  op;
   logic [31:0] addr;
   logic [31:0] wd;
   logic [31:0] pc;
   logic [31:0] rd;
   logic        exc;
   logic        wv;
   logic [31:0] wpc;
   logic [31:0] waddr;
   logic [31:0] wdata;

   dm_unit dut (
      .clk      (clk),
      .reset    (rst),
      .MemWrite (we),
      .DMOp     (op),
      .Addr     (addr),
      .WD       (wd),
      .PC       (pc),
      .RD       (rd),
      .addr_exc (exc),
      .wb_valid (wv),
      .wb_pc    (wpc),
      .wb_addr  (waddr),
      .wb_data  (wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference state.
   logic [31:0] mdl [NW];
   logic        m_valid;
   logic [31:0] m_pc, m_addr, m_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int unsigned op_size(input logic [2:0] o);
      if (o == 3'd0) return 4;
      if (o == 3'd1 || o == 3'd2) return 2;
      return 1;
   endfunction

   function automatic logic m_exc(input logic [2:0] o, input logic [31:0] a);
      if (o >= 3'd5) return 1'b1;
      if (a >= 32'(NW * 4)) return 1'b1;
      return (a % op_size(o)) != 0;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] o, input logic [31:0] a);
      logic [31:0] v;
      if (m_exc(o, a)) return 32'h0;
      v = mdl[a / 4] >> (8 * (a % 4));
      case (op_size(o))
         2: begin
            v = v & 32'h0000_FFFF;
            if (o == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
         end
         1: begin
            v = v & 32'h0000_00FF;
            if (o == 3'd3 && v >= 32'h80) v = v | 32'hFFFF_FF00;
         end
         default: ;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] m_merge(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] d);
      logic [31:0] mask;
      logic [31:0] old;
      int unsigned sh;
      old = mdl[a / 4];
      sh  = 8 * (a % 4);
      if (op_size(o) == 4) mask = 32'hFFFF_FFFF;
      else mask = ((32'd1 << (8 * op_size(o))) - 32'd1) << sh;
      return (old & ~mask) | ((d << sh) & mask);
   endfunction

   task automatic clear_model();
      for (int i = 0; i < int'(NW); i++) mdl[i] = 32'h0;
      m_valid = 1'b0;
      m_pc = 32'h0;
      m_addr = 32'h0;
      m_data = 32'h0;
   endtask

   always @(negedge rst) clear_model();

   // Model edge behaviour.
   always @(posedge clk) begin
      if (rst) begin
         if (we && !m_exc(op, addr)) begin
            m_data  = m_merge(op, addr, wd);
            m_pc    = pc;
            m_addr  = addr & 32'hFFFF_FFFC;
            m_valid = 1'b1;
            mdl[addr / 4] = m_data;
         end else begin
            m_valid = 1'b0;
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      chk("rd", rd, m_load(op, addr));
      chk("addr_exc", 32'(exc), 32'(m_exc(op, addr)));
      chk("wb_valid", 32'(wv), 32'(m_valid));
      chk("wb_pc", wpc, m_pc);
      chk("wb_addr", waddr, m_addr);
      chk("wb_data", wdata, m_data);
   end

   task automatic drive(input logic w, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] d);
      @(posedge clk);
      #1;
      we = w; op = o; addr = a; wd = d; pc = pc + 32'd4;
   endtask

   initial begin
      clear_model();
      rst = 1'b0; we = 1'b0; op = 3'd0; addr = 32'h0; wd = 32'h0; pc = 32'h0000_3000;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Reset state and first load.
      drive(0, 3'd0, 32'h0, 32'h0);
      @(negedge clk);
      chk("lit_reset_rd", rd, 32'h0);
      chk("lit_reset_exc", 32'(exc), 32'h0);
      chk("lit_reset_wbv", 32'(wv), 32'h0);

      // Word store then lane loads.
      drive(1, 3'd0, 32'h10, 32'h1234_5678);
      drive(0, 3'd3, 32'h11, 32'h0);
      @(negedge clk);
      chk("lit_sw_wbv", 32'(wv), 32'h1);
      chk("lit_sw_wbaddr", waddr, 32'h10);
      chk("lit_sw_wbdata", wdata, 32'h1234_5678);
      chk("lit_lb_11", rd, 32'h0000_0056);
      drive(0, 3'd4, 32'h13, 32'h0);
      @(negedge clk);
      chk("lit_lbu_13", rd, 32'h0000_0012);
      drive(0, 3'd2, 32'h12, 32'h0);
      @(negedge clk);
      chk("lit_lhu_12", rd, 32'h0000_1234);

      // Byte and half stores merging into one word.
      drive(1, 3'd3, 32'h20, 32'hFFFF_FF80);
      drive(0, 3'd3, 32'h20, 32'h0);
      @(negedge clk);
      chk("lit_sb_wbdata", wdata, 32'h0000_0080);
      chk("lit_lb_20", rd, 32'hFFFF_FF80);
      drive(0, 3'd4, 32'h20, 32'h0);
      @(negedge clk);
      chk("lit_lbu_20", rd, 32'h0000_0080);
      drive(1, 3'd1, 32'h22, 32'h1234_BEEF);
      drive(0, 3'd1, 32'h22, 32'h0);
      @(negedge clk);
      chk("lit_sh_wbdata", wdata, 32'hBEEF_0080);
      chk("lit_lh_22", rd, 32'hFFFF_BEEF);

      // Exception cases.
      drive(1, 3'd0, 32'h06, 32'hCAFE_F00D);
      @(negedge clk);
      chk("lit_sw06_exc", 32'(exc), 32'h1);
      drive(0, 3'd0, 32'h04, 32'h0);
      @(negedge clk);
      chk("lit_sw06_wbv", 32'(wv), 32'h0);
      chk("lit_lw04", rd, 32'h0);
      drive(0, 3'd1, 32'h03, 32'h0);
      @(negedge clk);
      chk("lit_lh03_exc", 32'(exc), 32'h1);
      chk("lit_lh03_rd", rd, 32'h0);
      drive(1, 3'd0, 32'h3000, 32'h5555_5555);
      @(negedge clk);
      chk("lit_sw3000_exc", 32'(exc), 32'h1);
      drive(0, 3'd6, 32'h10, 32'h0);
      @(negedge clk);
      chk("lit_op6_wbv", 32'(wv), 32'h0);
      chk("lit_op6_exc", 32'(exc), 32'h1);
      drive(0, 3'd0, 32'h2FFC, 32'h0);
      @(negedge clk);
      chk("lit_last_word_exc", 32'(exc), 32'h0);

      // Same-cycle store and load.
      drive(1, 3'd0, 32'h40, 32'hAAAA_5555);
      @(negedge clk);
      chk("lit_same_old", rd, 32'h0);
      drive(0, 3'd0, 32'h40, 32'h0);
      @(negedge clk);
      chk("lit_same_new", rd, 32'hAAAA_5555);

      // Mid-cycle reset clears the array and record without an edge.
      drive(1, 3'd0, 32'h100, 32'hDEAD_BEEF);
      drive(0, 3'd0, 32'h100, 32'h0);
      @(negedge clk);
      chk("lit_pre_rst_rd", rd, 32'hDEAD_BEEF);
      #2 rst = 1'b0;
      #1;
      chk("lit_rst_rd", rd, 32'h0);
      chk("lit_rst_wbv", 32'(wv), 32'h0);
      we = 1'b1; op = 3'd0; addr = 32'h100; wd = 32'h1111_1111;
      @(posedge clk);
      #1 rst = 1'b1;
      we = 1'b0;
      @(negedge clk);
      chk("lit_lost_store", rd, 32'h0);

      // Random traffic, addresses concentrated so loads hit stored data.
      for (int n = 0; n < 600; n++) begin
         logic [31:0] a;
         logic [2:0]  o;
         int unsigned sel;
         sel = $urandom_range(0, 99);
         if (sel < 80)      a = $urandom_range(0, 63);
         else if (sel < 92) a = 32'h2FF0 + $urandom_range(0, 31);
         else               a = $urandom;
         o = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                         : 3'($urandom_range(0, 4));
         if ($urandom_range(0, 3) != 0) a = a & ~32'(op_size(o) - 1);
         drive(1'($urandom_range(0, 1)), o, a, $urandom);
         if ($urandom_range(0, 149) == 0) begin
            @(negedge clk);
            #1 rst = 1'b0;
            #1;
            chk("rnd_rst_rd", rd, 32'h0);
            #1 rst = 1'b1;
         end
      end

      @(posedge clk);
      #1 we = 1'b0;
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dm_unit.md
Name: dm_unit

Overview:
- Data memory stage directly downstream of the execute-stage ALU.
- Takes the ALU result as a byte address and performs word, halfword and byte loads and stores on a single-port little-endian word array.
- Load data is combinational and goes to the write-back mux.
- Stores commit on the rising clock edge; a registered commit record is exported for trace and checking.

Parameters:
- DEPTH, 3072, number of 32-bit words (12 KiB, byte range 0x0000_0000–0x0000_2FFF)
- AW, 12, word-index width; must satisfy 2^AW >= DEPTH

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- MemWrite  input  1  store enable for the current instruction
- DMOp  input  3  access type: 0 word, 1 half signed, 2 half unsigned, 3 byte signed, 4 byte unsigned (5–7 illegal)
- Addr  input  32  byte address, straight from ALU output
- WD  input  32  store data (rt value); low byte/half used for sb/sh
- PC  input  32  PC of the current instruction, for the commit record
- RD  output  32  extended load data
- addr_exc  output  1  access is misaligned, out of range, or uses an illegal DMOp
- wb_valid  output  1  a store committed at the last edge
- wb_pc  output  32  PC of that store
- wb_addr  output  32  word-aligned address of that store
- wb_data  output  32  full word value after the merge

Behaviour:
- Reset asserted (reset=0): all DEPTH words cleared to 0 immediately, without waiting for an edge. Commit outputs cleared: wb_valid=0, wb_pc=wb_addr=wb_data=0.
- RD and addr_exc are combinational and have no reset value of their own. Under reset, RD reads 0 because the array is 0.
- Reset deasserted: first store may commit on the next rising edge.
- Word index = Addr[AW+1:2]. Byte lane = Addr[1:0]. Halfword lane = Addr[1].
- addr_exc=1 under any of these conditions:
  - Addr >= DEPTH*4, using the full 32-bit compare with no wrap-around
  - DMOp=0 and Addr[1:0]≠0
  - DMOp in {1,2} and Addr[0]≠0
  - DMOp >= 5
- addr_exc is evaluated whether or not MemWrite is set.
- Load path (combinational; RD is computed every cycle regardless of MemWrite):
  - if addr_exc, RD=0
  - word: RD = mem[idx]
  - half: select bits [16*Addr[1]+:16], then sign-extend (op 1) or zero-extend (op 2)
  - byte: select bits [8*Addr[1:0]+:8], then sign-extend (op 3) or zero-extend (op 4)
- Store path (rising edge, MemWrite=1, addr_exc=0):
  - Op 0 writes the whole word.
  - Ops 1/2 write WD[15:0] into the selected halfword.
  - Ops 3/4 write WD[7:0] into the selected byte.
  - Unselected lanes of the word are preserved.
- Store commit record, updated at the same edge:
  - wb_valid=1, wb_pc=PC, wb_addr={Addr[31:2],2'b00}, wb_data=merged word
  - any edge without a committed store: wb_valid=0, other wb_* fields hold their previous values
- Store with addr_exc=1: no array change, wb_valid=0 at the next edge.
- Load and store to the same word in the same cycle: RD returns the pre-edge contents, i.e. old data.
- Back-to-back stores to the same word across consecutive cycles merge cumulatively.
- Reset asserted between edges, or in the middle of a store cycle: the array clears at once, and a store pending for the next edge is lost if reset is still low at that edge.

Decomposition:
- Shared header (definations.v):
  - `DM_w=3'd0, `DM_h=3'd1, `DM_hu=3'd2, `DM_b=3'd3, `DM_bu=3'd4
  - DM base address and size constants
- One natural sub-module, dm_ext: combinational load lane-select and extension (word, DMOp, Addr[1:0] → RD).
- The store lane merge stays in dm_unit.

Test Plan:
- Reset then lw 0x0 → RD=0x00000000, addr_exc=0, wb_valid=0.
- sw 0x12345678 @0x10 → next cycle wb_valid=1, wb_addr=0x10, wb_data=0x12345678. Then:
  - lb @0x11 → RD=0x00000056
  - lbu @0x13 → RD=0x00000012
  - lhu @0x12 → RD=0x00001234
- sb 0x80 @0x20 → wb_data=0x00000080; lb @0x20 → RD=0xFFFFFF80, lbu → RD=0x00000080. Then sh 0xBEEF @0x22 → wb_data=0xBEEF0080; lh @0x22 → RD=0xFFFFBEEF.
- Exception cases:
  - sw @0x06 → addr_exc=1, next cycle wb_valid=0, lw @0x04 unchanged
  - lh @0x03 → addr_exc=1, RD=0
  - sw @0x3000 → addr_exc=1, no write
  - DMOp=6 → addr_exc=1
- Same-cycle store/load: sw 0xAAAA5555 @0x40 while reading @0x40 → RD shows old value 0 before the edge and 0xAAAA5555 after.
- Write 0xDEADBEEF @0x100; pull reset low mid-cycle → RD @0x100 becomes 0 immediately and wb_valid drops to 0 without a clock edge.
